// File: rtl/cordic_polar_avg_pkg.sv
// Shared types, widths and the phase-difference helper for the polar block averager.
package cordic_polar_avg_pkg;

    localparam int unsigned ANGLE_W = 16;
    localparam int unsigned MAG_W   = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    // Signed angle offset from the block reference, wrapped mod 2^16 into +/-180 deg.
    function automatic logic signed [ANGLE_W-1:0] wrap_diff(
        input logic [ANGLE_W-1:0] angle,
        input logic [ANGLE_W-1:0] ref_angle
    );
        logic [ANGLE_W-1:0] raw;
        raw = angle - ref_angle;
        return $signed(raw);
    endfunction

endpackage

// File: rtl/cordic_polar_avg.sv
// Block averager for the CORDIC {angle, magnitude} stream: averages 2^LOG2_AVG
// beats per block, unwrapping phase against the first beat of each block.
module cordic_polar_avg
    import cordic_polar_avg_pkg::*;
#(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned LOG2_AVG               = 4
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_reset,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tvalid,
    input  logic                              s00_axis_tlast,
    input  logic [3:0]                        s00_axis_tstrb,
    output logic                              s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                              m00_axis_tvalid,
    output logic                              m00_axis_tlast,
    output logic [3:0]                        m00_axis_tstrb,
    input  logic                              m00_axis_tready
);

    localparam int unsigned CNT_W   = LOG2_AVG + 1;
    localparam int unsigned PHASE_W = 17 + LOG2_AVG;
    localparam int unsigned MACC_W  = MAG_W + LOG2_AVG;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [ANGLE_W-1:0]                  ref_q, ref_d;
    logic signed [PHASE_W-1:0]           phase_acc_q, phase_acc_d;
    logic [MACC_W-1:0]                   mag_acc_q, mag_acc_d;
    logic                                tlast_acc_q, tlast_acc_d;
    logic                                s_tready_q, s_tready_d;
    logic                                m_tvalid_q, m_tvalid_d;
    logic                                m_tlast_q, m_tlast_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;

    logic [ANGLE_W-1:0]                  in_angle;
    logic [MAG_W-1:0]                    in_mag;
    logic                                accept;
    logic                                first_beat;
    logic [ANGLE_W-1:0]                  beat_ref;
    logic signed [ANGLE_W-1:0]           diff;
    logic signed [PHASE_W-1:0]           phase_sum;
    logic [MACC_W-1:0]                   mag_sum;
    logic                                tlast_sum;
    logic [ANGLE_W-1:0]                  mean_angle;
    logic [MAG_W-1:0]                    mean_mag;
    logic                                unused_strb;

    assign in_angle    = s00_axis_tdata[31:16];
    assign in_mag      = s00_axis_tdata[15:0];
    assign accept      = s00_axis_tvalid && s_tready_q;
    assign unused_strb = ^s00_axis_tstrb;

    assign s00_axis_tready = s_tready_q;
    assign m00_axis_tvalid = m_tvalid_q;
    assign m00_axis_tlast  = m_tlast_q;
    assign m00_axis_tdata  = m_tdata_q;
    assign m00_axis_tstrb  = 4'hF;

    // Next-state logic: running sums including the current beat, FSM and result load.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ref_d       = ref_q;
        phase_acc_d = phase_acc_q;
        mag_acc_d   = mag_acc_q;
        tlast_acc_d = tlast_acc_q;
        s_tready_d  = s_tready_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        m_tdata_d   = m_tdata_q;

        first_beat = (cnt_q == '0);
        beat_ref   = first_beat ? in_angle : ref_q;
        diff       = wrap_diff(in_angle, beat_ref);
        if (first_beat) begin
            phase_sum = '0;
            mag_sum   = MACC_W'(in_mag);
            tlast_sum = s00_axis_tlast;
        end else begin
            phase_sum = phase_acc_q + PHASE_W'(diff);
            mag_sum   = mag_acc_q + MACC_W'(in_mag);
            tlast_sum = tlast_acc_q | s00_axis_tlast;
        end
        mean_angle = beat_ref + ANGLE_W'(phase_sum >>> LOG2_AVG);
        mean_mag   = MAG_W'(mag_sum >> LOG2_AVG);

        case (state_q)
            ACCUM: begin
                s_tready_d = 1'b1;
                if (accept) begin
                    ref_d       = beat_ref;
                    phase_acc_d = phase_sum;
                    mag_acc_d   = mag_sum;
                    tlast_acc_d = tlast_sum;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d      = '0;
                        state_d    = EMIT;
                        s_tready_d = 1'b0;
                        m_tvalid_d = 1'b1;
                        m_tlast_d  = tlast_sum;
                        m_tdata_d  = C_M00_AXIS_TDATA_WIDTH'({mean_angle, mean_mag});
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            EMIT: begin
                s_tready_d = 1'b0;
                if (m00_axis_tready) begin
                    state_d    = ACCUM;
                    m_tvalid_d = 1'b0;
                    s_tready_d = 1'b1;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State, accumulator and output registers with synchronous reset.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_reset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            ref_q       <= '0;
            phase_acc_q <= '0;
            mag_acc_q   <= '0;
            tlast_acc_q <= 1'b0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
            phase_acc_q <= phase_acc_d;
            mag_acc_q   <= mag_acc_d;
            tlast_acc_q <= tlast_acc_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_tdata_q   <= m_tdata_d;
        end
    end

endmodule

// File: tb/tb_cordic_polar_avg.sv
// Directed bench for cordic_polar_avg with LOG2_AVG=2 (4-beat blocks).
module tb_cordic_polar_avg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [3:0]  s_tstrb = 4'hF;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [3:0]  m_tstrb;
    logic        m_tready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    cordic_polar_avg #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .LOG2_AVG(2)
    ) dut (
        .s00_axis_aclk  (clk),
        .s00_axis_reset (rst),
        .s00_axis_tdata (s_tdata),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tlast (s_tlast),
        .s00_axis_tstrb (s_tstrb),
        .s00_axis_tready(s_tready),
        .m00_axis_tdata (m_tdata),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tlast (m_tlast),
        .m00_axis_tstrb (m_tstrb),
        .m00_axis_tready(m_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one beat (called at a negedge); returns at the negedge after it is accepted.
    task automatic send(input logic [15:0] angle, input logic [15:0] mag, input logic last);
        int waited = 0;
        s_tdata  = {angle, mag};
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!s_tready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_tready) check("send_timeout", 32'(s_tready), 32'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Wait (bounded) for a result, check it, then step past the consuming edge.
    task automatic expect_out(input string tag, input logic [31:0] exp_data, input logic exp_last);
        int waited = 0;
        while (!m_tvalid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 32'(m_tvalid), 32'd1);
        check({tag, "_data"},  m_tdata, exp_data);
        check({tag, "_last"},  32'(m_tlast), 32'(exp_last));
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast",  32'(m_tlast),  32'd0);
        check("rst_tdata",  m_tdata,       32'h0);
        check("rst_tstrb",  32'(m_tstrb),  32'hF);
        check("rst_tready", 32'(s_tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", 32'(s_tready), 32'd1);

        // Basic mean with latency and tready drop
        send(16'd1000, 16'd100, 1'b0);
        send(16'd1000, 16'd200, 1'b0);
        send(16'd1000, 16'd300, 1'b0);
        check("basic_pre_valid", 32'(m_tvalid), 32'd0);
        send(16'd1000, 16'd400, 1'b0);
        check("basic_lat_valid",  32'(m_tvalid), 32'd1);
        check("basic_tready_low", 32'(s_tready), 32'd0);
        expect_out("basic", 32'h03E8_00FA, 1'b0);
        check("basic_valid_drop", 32'(m_tvalid), 32'd0);
        check("basic_tready_up",  32'(s_tready), 32'd1);

        // Phase wrap across 0/360
        send(16'd65530, 16'd10, 1'b0);
        send(16'd65534, 16'd10, 1'b0);
        send(16'd2,     16'd10, 1'b0);
        send(16'd6,     16'd10, 1'b0);
        expect_out("wrap", 32'h0000_000A, 1'b0);

        // Arithmetic shift floors toward -inf
        send(16'd100, 16'd1, 1'b0);
        send(16'd99,  16'd0, 1'b0);
        send(16'd99,  16'd0, 1'b0);
        send(16'd99,  16'd0, 1'b0);
        expect_out("floor", 32'h0063_0000, 1'b0);

        // tlast OR across the block, then cleared for the next block
        send(16'd0, 16'd4, 1'b0);
        send(16'd0, 16'd4, 1'b0);
        send(16'd0, 16'd4, 1'b1);
        send(16'd0, 16'd4, 1'b0);
        expect_out("tlast_set", 32'h0000_0004, 1'b1);
        send(16'd0, 16'd8, 1'b0);
        send(16'd0, 16'd8, 1'b0);
        send(16'd0, 16'd8, 1'b0);
        send(16'd0, 16'd8, 1'b0);
        expect_out("tlast_clr", 32'h0000_0008, 1'b0);

        // Backpressure: result held, input stalled, next block intact
        m_tready = 1'b0;
        send(16'd2000, 16'd1, 1'b0);
        send(16'd2000, 16'd2, 1'b0);
        send(16'd2000, 16'd3, 1'b0);
        send(16'd2000, 16'd4, 1'b0);
        s_tdata  = {16'd3000, 16'd5};
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",  32'(m_tvalid), 32'd1);
            check("bp_data",   m_tdata,       32'h07D0_0002);
            check("bp_tready", 32'(s_tready), 32'd0);
            @(negedge clk);
        end
        m_tready = 1'b1;
        @(negedge clk);
        check("bp_release_valid",  32'(m_tvalid), 32'd0);
        check("bp_release_tready", 32'(s_tready), 32'd1);
        send(16'd3000, 16'd5, 1'b0);
        send(16'd3000, 16'd6, 1'b0);
        send(16'd3000, 16'd7, 1'b0);
        send(16'd3000, 16'd8, 1'b0);
        expect_out("bp_next", 32'h0BB8_0006, 1'b0);

        // Reset mid-block discards the partial sums
        send(16'd0, 16'd1000, 1'b0);
        send(16'd0, 16'd1000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid",  32'(m_tvalid), 32'd0);
        check("midrst_tready", 32'(s_tready), 32'd0);
        send(16'd0, 16'd8, 1'b0);
        send(16'd0, 16'd8, 1'b0);
        send(16'd0, 16'd8, 1'b0);
        send(16'd0, 16'd8, 1'b0);
        expect_out("midrst", 32'h0000_0008, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("no_stale_valid", 32'(m_tvalid), 32'd0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_polar_avg.md
# cordic_polar_avg

Block averager that sits directly downstream of the CORDIC rectangular-to-polar stage in the VNA receive chain. It consumes the CORDIC's packed {angle, magnitude} AXI-Stream and accumulates 2^LOG2_AVG consecutive samples. It emits one averaged {angle, magnitude} word per block. Phase is unwrapped relative to the first sample of each block, so blocks straddling 0°/360° average correctly.

## Interface
- C_S00_AXIS_TDATA_WIDTH, 32, input word width; fixed at 32.
- C_M00_AXIS_TDATA_WIDTH, 32, output word width; fixed at 32.
- LOG2_AVG, 4, log2 of samples per block; legal range 0..10.

Ports (single clock domain; reset is synchronous and active-high):
- s00_axis_aclk  input  1  sole clock; both AXIS interfaces run on it.
- s00_axis_reset  input  1  reset, synchronous and active-high.
- s00_axis_tdata  input  32  [31:16] angle, unsigned, 65536 = 360°; [15:0] magnitude, unsigned.
- s00_axis_tvalid  input  1  input beat valid.
- s00_axis_tlast  input  1  sweep-point marker.
- s00_axis_tstrb  input  4  ignored.
- s00_axis_tready  output  1  input accept.
- m00_axis_tdata  output  32  [31:16] mean angle; [15:0] mean magnitude.
- m00_axis_tvalid  output  1  result valid.
- m00_axis_tlast  output  1  OR of input tlast over the block.
- m00_axis_tstrb  output  4  constant 4'hF.
- m00_axis_tready  input  1  downstream accept.

## Operation
- FSM states:
  - ACCUM: s00_axis_tready=1.
  - EMIT: s00_axis_tready=0, m00_axis_tvalid=1.
- ACCUM: each accepted beat (tvalid && tready) increments cnt, which is LOG2_AVG+1 bits wide.
- First beat of a block (cnt==0):
  - ref ← angle.
  - phase_acc ← 0.
  - mag_acc ← mag.
  - tlast_acc ← tlast.
- Later beats:
  - d = signed16(angle − ref), computed mod 2^16.
  - phase_acc += d; phase_acc is signed, 17+LOG2_AVG bits.
  - mag_acc += mag; mag_acc is unsigned, 16+LOG2_AVG bits.
  - tlast_acc |= tlast.
- On the 2^LOG2_AVG-th accepted beat, the result registers load and the FSM goes to EMIT. The result includes that beat's contribution.
  - mean_mag = mag_acc >> LOG2_AVG (floor).
  - mean_angle = (ref + (phase_acc >>> LOG2_AVG))[15:0]. The shift is arithmetic, i.e. floor toward −∞.
  - cnt ← 0.
- EMIT: the output stays stable until m00_axis_tready=1, then the FSM returns to ACCUM on the next cycle.
- Samples must lie within ±180° (exclusive) of ref. Beyond that, d aliases; this is accepted, not flagged.
- LOG2_AVG=0: every beat is its own block, so output = input registered.
- Reset during ACCUM discards the partial block. Reset during EMIT drops the pending result.

## Timing
- Reset values:
  - m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, m00_axis_tstrb=4'hF.
  - s00_axis_tready=0 while reset is high, 1 the first cycle after.
  - State=ACCUM, cnt=0.
- Latency: m00_axis_tvalid rises the cycle after the final beat of a block is accepted.
- Throughput:
  - s00_axis_tready drops in the cycle after the final beat is accepted.
  - Minimum block period is 2^LOG2_AVG+1 cycles: one bubble per block when m00_axis_tready is held high.
- s00_axis_tready depends only on registered state, never combinationally on m00_axis_tready.
- Input tvalid during EMIT is not accepted; the upstream CORDIC holds its output under backpressure.

## Structure
- Package cordic_polar_avg_pkg holds:
  - typedef enum logic {ACCUM, EMIT} state_t.
  - ANGLE_W=16 and MAG_W=16.
  - function wrap_diff(angle, ref), returning a signed 16-bit value.
- Single module, no sub-modules: FSM, counter and the two accumulators are all small.

## Test plan
- LOG2_AVG=2, m00 tready high. Input mag 100, 200, 300, 400, all angle 1000 (0x03E8) → one output 0x03E800FA, tvalid high exactly the cycle after the 4th accept.
- Wrap: LOG2_AVG=2, angles 65530, 65534, 2, 6, mag 10 → d sum 24, mean offset 6 → output 0x0000000A.
- Floor: LOG2_AVG=2, angles 100, 99, 99, 99; mags 1, 0, 0, 0 → phase sum −3 >>> 2 = −1 → output 0x00630000.
- Backpressure: hold m00_axis_tready=0 for 5 cycles after a result →
  - tdata/tvalid stable.
  - s00_axis_tready=0 throughout.
  - Next block's inputs all accepted after release, none lost.
- tlast: tlast on the 3rd of 4 beats → output tlast=1; the following block (no tlast) → output tlast=0.
- Reset mid-block: accept 2 beats (mag 1000), pulse reset 1 cycle, then 4 beats of mag 8 angle 0 → single output 0x00000008, no stale output.
